// File: rtl/lock_sequencer_if.sv
// ============================================================================
// Module      : lock_sequencer_if
// Description : Water-control command/status interface between the lock
//               sequencer (master) and the water controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lock_sequencer_if;
    logic w_up;
    logic w_down;
    logic water_high;
    logic water_low;

    modport master (
        output w_up,
        output w_down,
        input  water_high,
        input  water_low
    );

    modport slave (
        input  w_up,
        input  w_down,
        output water_high,
        output water_low
    );
endinterface

`default_nettype wire

// File: rtl/lock_sequencer.sv
// ============================================================================
// Module      : lock_sequencer
// Description : Canal-lock master sequencer; opens gates for boats and issues
//               raise/lower commands to the water controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_sequencer #(
    parameter int DWELL   = 20,
    parameter int TIMEOUT = 127
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         arrive_lo,
    input  wire logic         arrive_hi,
    lock_sequencer_if.master  water,
    output logic              gate_lo_open,
    output logic              gate_hi_open,
    output logic              boat_aboard,
    output logic              at_high,
    output logic              fault
);

    localparam logic [3:0] ST_LO_IDLE    = 4'd0;
    localparam logic [3:0] ST_LO_OPEN    = 4'd1;
    localparam logic [3:0] ST_RAISE_CMD  = 4'd2;
    localparam logic [3:0] ST_RAISE_WAIT = 4'd3;
    localparam logic [3:0] ST_HI_IDLE    = 4'd4;
    localparam logic [3:0] ST_HI_OPEN    = 4'd5;
    localparam logic [3:0] ST_LOWER_CMD  = 4'd6;
    localparam logic [3:0] ST_LOWER_WAIT = 4'd7;
    localparam logic [3:0] ST_FAULT      = 4'd8;

    localparam logic [7:0] DWELL_LAST   = 8'(DWELL - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [3:0] state;
    logic [3:0] state_next;
    logic [7:0] timer;
    logic [7:0] timer_next;
    logic       cargo;
    logic       cargo_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_LO_IDLE;
            timer <= 8'd0;
            cargo <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            cargo <= cargo_next;
        end
    end

    // Timer only advances while dwelling or waiting; any transition clears it.
    always_comb begin
        state_next = state;
        timer_next = 8'd0;
        cargo_next = cargo;
        case (state)
            ST_LO_IDLE: begin
                if (arrive_lo)      state_next = ST_LO_OPEN;
                else if (arrive_hi) state_next = ST_RAISE_CMD;
            end
            ST_LO_OPEN: begin
                if (timer == DWELL_LAST) begin
                    cargo_next = ~cargo;
                    state_next = cargo ? ST_LO_IDLE : ST_RAISE_CMD;
                end else begin
                    timer_next = timer + 8'd1;
                end
            end
            ST_RAISE_CMD: state_next = ST_RAISE_WAIT;
            ST_RAISE_WAIT: begin
                if (water.water_high)           state_next = ST_HI_OPEN;
                else if (timer == TIMEOUT_LAST) state_next = ST_FAULT;
                else                            timer_next = timer + 8'd1;
            end
            ST_HI_IDLE: begin
                if (arrive_hi)      state_next = ST_HI_OPEN;
                else if (arrive_lo) state_next = ST_LOWER_CMD;
            end
            ST_HI_OPEN: begin
                if (timer == DWELL_LAST) begin
                    cargo_next = ~cargo;
                    state_next = cargo ? ST_HI_IDLE : ST_LOWER_CMD;
                end else begin
                    timer_next = timer + 8'd1;
                end
            end
            ST_LOWER_CMD: state_next = ST_LOWER_WAIT;
            ST_LOWER_WAIT: begin
                if (water.water_low)            state_next = ST_LO_OPEN;
                else if (timer == TIMEOUT_LAST) state_next = ST_FAULT;
                else                            timer_next = timer + 8'd1;
            end
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_LO_IDLE;
        endcase
    end

    always_comb begin
        water.w_up   = 1'b0;
        water.w_down = 1'b0;
        gate_lo_open = 1'b0;
        gate_hi_open = 1'b0;
        at_high      = 1'b0;
        fault        = 1'b0;
        boat_aboard  = cargo;
        case (state)
            ST_LO_OPEN:   gate_lo_open = 1'b1;
            ST_RAISE_CMD: water.w_up   = 1'b1;
            ST_HI_IDLE:   at_high      = 1'b1;
            ST_HI_OPEN: begin
                gate_hi_open = 1'b1;
                at_high      = 1'b1;
            end
            ST_LOWER_CMD: begin
                water.w_down = 1'b1;
                at_high      = 1'b1;
            end
            ST_FAULT:     fault        = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_lock_sequencer.sv
// ============================================================================
// Module      : tb_lock_sequencer
// Description : Directed self-checking bench for lock_sequencer (DWELL=20,
//               TIMEOUT=50); the bench plays the water controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lock_sequencer;

    logic clk;
    logic reset;
    logic arrive_lo;
    logic arrive_hi;
    logic gate_lo_open;
    logic gate_hi_open;
    logic boat_aboard;
    logic at_high;
    logic fault;

    int checks;
    int errors;
    int cnt;

    lock_sequencer_if wif ();

    lock_sequencer #(.DWELL(20), .TIMEOUT(50)) dut (
        .clk          (clk),
        .reset        (reset),
        .arrive_lo    (arrive_lo),
        .arrive_hi    (arrive_hi),
        .water        (wif.master),
        .gate_lo_open (gate_lo_open),
        .gate_hi_open (gate_hi_open),
        .boat_aboard  (boat_aboard),
        .at_high      (at_high),
        .fault        (fault)
    );

    // {w_up, w_down, gate_lo, gate_hi, boat, at_high, fault}
    logic [6:0] obs;
    assign obs = {wif.w_up, wif.w_down, gate_lo_open, gate_hi_open,
                  boat_aboard, at_high, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic count_lo();
        cnt = 0;
        while (gate_lo_open === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    task automatic count_hi();
        cnt = 0;
        while (gate_hi_open === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        arrive_lo = 1'b0;
        arrive_hi = 1'b0;
        wif.water_high = 1'b0;
        wif.water_low  = 1'b0;
        tick();
        tick();
        check("reset_outputs", 32'(obs), 32'h00);
        reset = 1'b0;
        tick();
        check("idle_after_reset", 32'(obs), 32'h00);

        // Upbound boat
        arrive_lo = 1'b1;
        tick();
        check("up_lo_open", 32'(obs), 32'(7'b0010000));
        arrive_lo = 1'b0;
        count_lo();
        check("up_lo_dwell", 32'(cnt), 32'd20);
        check("up_raise_cmd", 32'(obs), 32'(7'b1000100));
        tick();
        check("up_raise_wait", 32'(obs), 32'(7'b0000100));
        repeat (29) tick();
        check("up_still_waiting", 32'(obs), 32'(7'b0000100));
        wif.water_high = 1'b1;
        tick();
        check("up_hi_open", 32'(obs), 32'(7'b0001110));
        wif.water_high = 1'b0;
        count_hi();
        check("up_hi_dwell", 32'(cnt), 32'd20);
        check("up_hi_idle", 32'(obs), 32'(7'b0000010));

        // Both requests at high: high gate first, then downbound
        arrive_lo = 1'b1;
        arrive_hi = 1'b1;
        tick();
        check("both_hi_first", 32'(obs), 32'(7'b0001010));
        arrive_lo = 1'b0;
        arrive_hi = 1'b0;
        count_hi();
        check("down_hi_dwell", 32'(cnt), 32'd20);
        check("down_lower_cmd", 32'(obs), 32'(7'b0100110));
        tick();
        check("down_lower_wait", 32'(obs), 32'(7'b0000100));
        repeat (10) tick();
        wif.water_low = 1'b1;
        tick();
        check("down_lo_open", 32'(obs), 32'(7'b0010100));
        wif.water_low = 1'b0;
        count_lo();
        check("down_lo_dwell", 32'(cnt), 32'd20);
        check("down_lo_idle", 32'(obs), 32'h00);

        // Both requests at low: low gate first; then asynchronous reset
        arrive_lo = 1'b1;
        arrive_hi = 1'b1;
        tick();
        check("both_lo_first", 32'(obs), 32'(7'b0010000));
        arrive_lo = 1'b0;
        arrive_hi = 1'b0;
        repeat (5) tick();
        #3 reset = 1'b1;
        #1 check("async_reset_open", 32'(obs), 32'h00);
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_idle", 32'(obs), 32'h00);

        // Fetch, with water_high arriving on the last timeout edge
        arrive_hi = 1'b1;
        tick();
        check("fetch_raise_cmd", 32'(obs), 32'(7'b1000000));
        arrive_hi = 1'b0;
        tick();
        check("fetch_raise_wait", 32'(obs), 32'h00);
        repeat (49) tick();
        check("coinc_no_fault_yet", 32'(obs), 32'h00);
        wif.water_high = 1'b1;
        tick();
        check("coinc_hi_open", 32'(obs), 32'(7'b0001010));
        wif.water_high = 1'b0;
        count_hi();
        check("fetch_hi_dwell", 32'(cnt), 32'd20);
        check("fetch_lower_cmd", 32'(obs), 32'(7'b0100110));
        tick();
        check("fetch_lower_wait", 32'(obs), 32'(7'b0000100));
        repeat (5) tick();
        #3 reset = 1'b1;
        #1 check("async_reset_wait", 32'(obs), 32'h00);
        tick();
        reset = 1'b0;
        arrive_lo = 1'b1;
        tick();
        check("resume_lo_idle", 32'(obs), 32'(7'b0010000));
        arrive_lo = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check("reset_pulse", 32'(obs), 32'h00);

        // Timeout with no water status
        tick();
        arrive_hi = 1'b1;
        tick();
        check("to_raise_cmd", 32'(obs), 32'(7'b1000000));
        arrive_hi = 1'b0;
        tick();
        repeat (49) tick();
        check("to_before_fault", 32'(obs), 32'h00);
        tick();
        check("to_fault", 32'(obs), 32'(7'b0000001));
        arrive_lo = 1'b1;
        arrive_hi = 1'b1;
        wif.water_high = 1'b1;
        wif.water_low  = 1'b1;
        repeat (5) tick();
        check("fault_sticky", 32'(obs), 32'(7'b0000001));
        arrive_lo = 1'b0;
        arrive_hi = 1'b0;
        wif.water_high = 1'b0;
        wif.water_low  = 1'b0;
        reset = 1'b1;
        #1 check("fault_cleared", 32'(obs), 32'h00);
        tick();
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
